pueo_trig_scheduler: RTL

Admits trigger requests into the readout datapath in the `aclk` domain. A request is issued only when all three hold: a run is active, the minimum-spacing holdoff has expired, and the URAM event buffer has a free slot. Issued triggers go out as a registered `trig_time`/`trig_time_valid` pair plus an event number, and feed the trigger-address path into the URAM readout and event buffer. The block also tracks outstanding events against readout-complete pulses, counts dropped requests, and sequences run start, stop and drain.

---
 rtl/pueo_trig_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pueo_trig_scheduler.sv
// Trigger admission for the readout datapath: gates requests on run state, holdoff and free event slots.
// Issue strobe 1 cycle after request; status outputs registered 1 cycle after cause; refused requests are dropped and counted.
module pueo_trig_scheduler #(
    parameter int NBUF     = 4,
    parameter int HOLDOFF  = 16,
    parameter int TIMEBITS = 16
) (
    input  logic                        aclk_i,
    input  logic                        aclk_rst_i,
    input  logic                        run_rst_i,
    input  logic                        run_stop_i,
    input  logic                        trig_req_i,
    input  logic [TIMEBITS-1:0]         trig_req_time_i,
    input  logic                        readout_done_i,
    output logic [TIMEBITS-1:0]         trig_time_o,
    output logic                        trig_time_valid_o,
    output logic [15:0]                 trig_num_o,
    output logic [$clog2(NBUF+1)-1:0]   outstanding_o,
    output logic [15:0]                 dropped_o,
    output logic                        busy_o,
    output logic [1:0]                  state_o,
    output logic                        err_o
);

    localparam int OW = $clog2(NBUF + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [OW-1:0] NBUF_C    = OW'(NBUF);
    localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 1) ? HW'(HOLDOFF - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    logic [HW-1:0]         r_hold;
    logic [OW-1:0]         r_out;
    logic [15:0]           r_trig_num;
    logic [15:0]           r_dropped;
    logic                  r_err;
    logic                  r_busy;
    logic [TIMEBITS-1:0]   r_trig_time;
    logic                  r_trig_vld;
    logic [15:0]           r_trig_num_out;

    state_t                w_state_nxt;
    logic [HW-1:0]         w_hold_nxt;
    logic [OW-1:0]         w_out_nxt;
    logic [15:0]           w_num_nxt;
    logic [15:0]           w_drop_nxt;
    logic                  w_err_nxt;
    logic                  w_busy_nxt;
    logic                  w_req_ok;
    logic                  w_issue;
    logic                  w_done_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_out_nxt   = r_out;
        w_num_nxt   = r_trig_num;
        w_drop_nxt  = r_dropped;
        w_err_nxt   = r_err;

        // A request coinciding with a run stop or run reset is neither issued nor counted.
        w_req_ok  = trig_req_i & (r_state == ST_RUN) & ~run_stop_i & ~run_rst_i;
        w_issue   = w_req_ok & (r_hold == '0) & (r_out < NBUF_C);
        w_done_ok = readout_done_i & (r_out != '0);

        if (run_rst_i && run_stop_i) begin
            w_state_nxt = ST_IDLE;
        end else if (run_stop_i && (r_state == ST_RUN)) begin
            w_state_nxt = ST_DRAIN;
        end else if (run_rst_i) begin
            w_state_nxt = ST_RUN;
        end else if ((r_state == ST_DRAIN) && (r_out == '0)) begin
            w_state_nxt = ST_IDLE;
        end

        if (w_issue) begin
            w_hold_nxt = HOLD_LOAD;
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - 1'b1;
        end

        if (w_issue && !w_done_ok) begin
            w_out_nxt = r_out + 1'b1;
        end else if (!w_issue && w_done_ok) begin
            w_out_nxt = r_out - 1'b1;
        end

        if (w_issue) begin
            w_num_nxt = r_trig_num + 16'd1;
        end

        if (w_req_ok && !w_issue && (r_dropped != 16'hFFFF)) begin
            w_drop_nxt = r_dropped + 16'd1;
        end

        if (readout_done_i && (r_out == '0)) begin
            w_err_nxt = 1'b1;
        end

        // The downstream event buffer restarts with the run, so run reset discards everything.
        if (run_rst_i) begin
            w_hold_nxt = '0;
            w_out_nxt  = '0;
            w_num_nxt  = '0;
            w_drop_nxt = '0;
            w_err_nxt  = 1'b0;
        end

        w_busy_nxt = (w_state_nxt == ST_RUN) & ((w_hold_nxt != '0) | (w_out_nxt == NBUF_C));
    end

    always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
        if (aclk_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
        if (aclk_rst_i) begin
            r_hold         <= '0;
            r_out          <= '0;
            r_trig_num     <= '0;
            r_dropped      <= '0;
            r_err          <= 1'b0;
            r_busy         <= 1'b0;
            r_trig_time    <= '0;
            r_trig_vld     <= 1'b0;
            r_trig_num_out <= '0;
        end else begin
            r_hold     <= w_hold_nxt;
            r_out      <= w_out_nxt;
            r_trig_num <= w_num_nxt;
            r_dropped  <= w_drop_nxt;
            r_err      <= w_err_nxt;
            r_busy     <= w_busy_nxt;
            r_trig_vld <= w_issue;
            if (w_issue) begin
                r_trig_time    <= trig_req_time_i;
                r_trig_num_out <= r_trig_num;
            end
        end
    end

    assign trig_time_o       = r_trig_time;
    assign trig_time_valid_o = r_trig_vld;
    assign trig_num_o        = r_trig_num_out;
    assign outstanding_o     = r_out;
    assign dropped_o         = r_dropped;
    assign busy_o            = r_busy;
    assign state_o           = r_state;
    assign err_o             = r_err;

endmodule
